// File: rtl/pwr_fail_sequencer.sv
// Power-fail sequencer: halts the executor, tri-states the TAP drivers and interrupts the CPU on a
// supply failure, then restarts after a pwr_ok hold-off. Optional event counter: PWR_FAIL_CNT_EN.
//
// state            | meaning
// -----------------+---------------------------------------------------------------
// IDLE         (0) | normal operation, waiting for a pwr_fail pulse
// HALT         (1) | halt_req raised, waiting for halt_ack or the ack timeout
// DISABLE      (2) | one cycle; drivers tri-stated and irq_pwr raised on exit
// WAIT_RESTORE (3) | drivers off, waiting for pwr_ok
// HOLDOFF      (4) | counting consecutive pwr_ok-high cycles before restart
// RESTART      (5) | one cycle; releases halt_req/drv_disable, pulses exec_restart
module pwr_fail_sequencer #(
   parameter int ACK_TIMEOUT    = 1000,
   parameter int HOLDOFF_CYCLES = 50000,
   parameter int CNT_WIDTH      = 17
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pwr_fail,
   input  logic       pwr_ok,
   input  logic       halt_ack,
   input  logic       irq_clr,
   output logic       halt_req,
   output logic       drv_disable,
   output logic       irq_pwr,
   output logic       timeout_flag,
   output logic       exec_restart,
   output logic [2:0] state,
   output logic [7:0] fail_count
);

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_HALT         = 3'd1,
      ST_DISABLE      = 3'd2,
      ST_WAIT_RESTORE = 3'd3,
      ST_HOLDOFF      = 3'd4,
      ST_RESTART      = 3'd5
   } state_t;

   localparam logic [CNT_WIDTH-1:0] ACK_LAST  = CNT_WIDTH'(ACK_TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 halt_req_q, halt_req_d;
   logic                 drv_q, drv_d;
   logic                 irq_q, irq_d;
   logic                 to_q, to_d;
   logic                 restart_q, restart_d;
   logic                 set_irq, set_to;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         halt_req_q <= 1'b0;
         drv_q      <= 1'b0;
         irq_q      <= 1'b0;
         to_q       <= 1'b0;
         restart_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         halt_req_q <= halt_req_d;
         drv_q      <= drv_d;
         irq_q      <= irq_d;
         to_q       <= to_d;
         restart_q  <= restart_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      halt_req_d = halt_req_q;
      drv_d      = drv_q;
      restart_d  = 1'b0;
      set_irq    = 1'b0;
      set_to     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pwr_fail) begin
               state_d    = ST_HALT;
               cnt_d      = '0;
               halt_req_d = 1'b1;
            end
         end
         ST_HALT: begin
            cnt_d = cnt_q + CNT_ONE;
            // An ack on the terminal cycle takes priority over the timeout.
            if (halt_ack) begin
               state_d = ST_DISABLE;
            end else if (cnt_q == ACK_LAST) begin
               state_d = ST_DISABLE;
               set_to  = 1'b1;
            end
         end
         ST_DISABLE: begin
            state_d = ST_WAIT_RESTORE;
            drv_d   = 1'b1;
            set_irq = 1'b1;
         end
         ST_WAIT_RESTORE: begin
            if (pwr_ok) begin
               state_d = ST_HOLDOFF;
               cnt_d   = '0;
            end
         end
         ST_HOLDOFF: begin
            if (!pwr_ok || pwr_fail) begin
               state_d = ST_WAIT_RESTORE;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_RESTART;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_RESTART: begin
            state_d    = ST_IDLE;
            halt_req_d = 1'b0;
            drv_d      = 1'b0;
            restart_d  = 1'b1;
         end
         default: begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            halt_req_d = 1'b0;
            drv_d      = 1'b0;
         end
      endcase

      // Sticky flags: a set in the same cycle as irq_clr wins.
      irq_d = set_irq | (irq_q & ~irq_clr);
      to_d  = set_to  | (to_q  & ~irq_clr);
   end

   assign state        = state_q;
   assign halt_req     = halt_req_q;
   assign drv_disable  = drv_q;
   assign irq_pwr      = irq_q;
   assign timeout_flag = to_q;
   assign exec_restart = restart_q;

`ifdef PWR_FAIL_CNT_EN
   logic [7:0] fail_count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fail_count_q <= 8'd0;
      end else if (pwr_fail && (fail_count_q != 8'hFF)) begin
         fail_count_q <= fail_count_q + 8'd1;
      end
   end

   assign fail_count = fail_count_q;
`else
   assign fail_count = 8'd0;
`endif

endmodule

// File: tb/tb_pwr_fail_sequencer.sv
// Self-checking bench for pwr_fail_sequencer: directed scenarios plus randomized stimulus,
// compared each cycle against a phase/elapsed-time reference model.
module tb_pwr_fail_sequencer;

   localparam int ACK = 8;
   localparam int HOLD = 16;

   logic       clk;
   logic       reset_n;
   logic       pwr_fail, pwr_ok, halt_ack, irq_clr;
   logic       halt_req, drv_disable, irq_pwr, timeout_flag, exec_restart;
   logic [2:0] state;
   logic [7:0] fail_count;

   int n_checks = 0;
   int n_fail   = 0;

   pwr_fail_sequencer #(
      .ACK_TIMEOUT   (ACK),
      .HOLDOFF_CYCLES(HOLD),
      .CNT_WIDTH     (5)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pwr_fail    (pwr_fail),
      .pwr_ok      (pwr_ok),
      .halt_ack    (halt_ack),
      .irq_clr     (irq_clr),
      .halt_req    (halt_req),
      .drv_disable (drv_disable),
      .irq_pwr     (irq_pwr),
      .timeout_flag(timeout_flag),
      .exec_restart(exec_restart),
      .state       (state),
      .fail_count  (fail_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase code plus elapsed-cycle counters.
   int m_phase;
   int m_halt_elapsed;
   int m_good_run;
   bit m_hreq, m_drv, m_irq, m_to, m_rs;
   int m_fc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] dut_vec();
      return {state, halt_req, drv_disable, irq_pwr, timeout_flag, exec_restart, fail_count};
   endfunction

   function automatic logic [15:0] model_vec();
      logic [7:0] fc;
`ifdef PWR_FAIL_CNT_EN
      fc = 8'(m_fc);
`else
      fc = 8'd0;
`endif
      return {3'(m_phase), m_hreq, m_drv, m_irq, m_to, m_rs, fc};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_halt_elapsed = 0; m_good_run = 0;
      m_hreq = 0; m_drv = 0; m_irq = 0; m_to = 0; m_rs = 0; m_fc = 0;
   endtask

   task automatic model_step(input bit pf, input bit ok, input bit ack, input bit clr);
      bit raise_irq = 0;
      bit raise_to = 0;
      m_rs = 0;
      if (pf && m_fc < 255) m_fc++;
      case (m_phase)
         0: if (pf) begin m_phase = 1; m_halt_elapsed = 0; m_hreq = 1; end
         1: begin
            m_halt_elapsed++;
            if (ack) m_phase = 2;
            else if (m_halt_elapsed == ACK) begin m_phase = 2; raise_to = 1; end
         end
         2: begin m_phase = 3; m_drv = 1; raise_irq = 1; end
         3: if (ok) begin m_phase = 4; m_good_run = 0; end
         4: begin
            if (!ok || pf) m_phase = 3;
            else begin
               m_good_run++;
               if (m_good_run == HOLD) m_phase = 5;
            end
         end
         5: begin m_phase = 0; m_hreq = 0; m_drv = 0; m_rs = 1; end
         default: m_phase = 0;
      endcase
      if (raise_irq) m_irq = 1; else if (clr) m_irq = 0;
      if (raise_to) m_to = 1; else if (clr) m_to = 0;
   endtask

   task automatic cyc(input bit pf, input bit ok, input bit ack, input bit clr);
      pwr_fail = pf; pwr_ok = ok; halt_ack = ack; irq_clr = clr;
      @(posedge clk);
      model_step(pf, ok, ack, clr);
      #1;
      check("outs", 32'(dut_vec()), 32'(model_vec()));
   endtask

   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_reset", 32'(dut_vec()), 32'(model_vec()));
      check("async_reset_zero", 32'(dut_vec()), 32'd0);
      #4;
      reset_n = 1'b1;
   endtask

   task automatic wait_restart(input string tag, input int exp_n);
      int n = 0;
      bit found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cyc(0, 1, 0, 0);
         n++;
         if (exec_restart) found = 1;
      end
      check({tag, "_seen"}, 32'(found), 32'd1);
      check({tag, "_len"}, 32'(n), 32'(exp_n));
   endtask

   initial begin
      int n;
      bit found;
      bit ok_lvl;

      reset_n = 1'b0; pwr_fail = 0; pwr_ok = 0; halt_ack = 0; irq_clr = 0;
      model_reset();
      #12;
      check("reset_state", 32'(dut_vec()), 32'd0);
      reset_n = 1'b1;

      // Ack-terminated sequence with full hold-off.
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      check("halt_req_latency", 32'(halt_req), 32'd1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      check("disable_state", 32'(state), 32'd2);
      cyc(0, 0, 0, 0);
      check("drv_after_ack", 32'({drv_disable, irq_pwr, timeout_flag}), 32'b110);
      wait_restart("restart1", 18);
      check("released", 32'({halt_req, drv_disable}), 32'd0);
      cyc(0, 1, 0, 0);
      check("restart_single", 32'(exec_restart), 32'd0);

      // Ack timeout.
      cyc(1, 0, 0, 0);
      n = 1; found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         cyc(0, 0, 0, 0);
         if (state == 3'd1) n++; else found = 1;
      end
      check("halt_len", 32'(n), 32'(ACK));
      check("timeout_set", 32'({state, timeout_flag}), 32'({3'd2, 1'b1}));
      cyc(0, 0, 0, 0);
      check("irq_set", 32'(irq_pwr), 32'd1);
      cyc(0, 0, 0, 1);
      check("irq_clr", 32'({irq_pwr, timeout_flag}), 32'd0);

      // pwr_ok drop during hold-off.
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
      check("holdoff_mid", 32'(state), 32'd4);
      cyc(0, 0, 0, 0);
      check("holdoff_drop", 32'(state), 32'd3);
      wait_restart("restart2", 18);

      // Extra pulses ignored; clear coinciding with set.
      cyc(0, 0, 0, 1);
      check("irq_pre", 32'(irq_pwr), 32'd0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      check("pf_in_halt", 32'(state), 32'd1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      check("set_beats_clr", 32'(irq_pwr), 32'd1);
      cyc(1, 0, 0, 0);
      check("pf_in_wait", 32'(state), 32'd3);
      wait_restart("restart3", 18);

      // Asynchronous reset while in HOLDOFF.
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      check("pre_reset_holdoff", 32'(state), 32'd4);
      do_reset();

      // Event counter (tied to zero when the feature is not built).
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
`ifdef PWR_FAIL_CNT_EN
      check("fail_count_3", 32'(fail_count), 32'd3);
`else
      check("fail_count_3", 32'(fail_count), 32'd0);
`endif
      for (int i = 0; i < 297; i++) cyc(1, 1, 1, 0);
`ifdef PWR_FAIL_CNT_EN
      check("fail_count_sat", 32'(fail_count), 32'd255);
`else
      check("fail_count_sat", 32'(fail_count), 32'd0);
`endif
      do_reset();

      // Randomized stimulus against the model.
      ok_lvl = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 23) == 0) ok_lvl = ~ok_lvl;
         cyc(bit'($urandom_range(0, 29) == 0), ok_lvl,
             bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
